// File: rtl/pulse_burst_counter.sv
// Pulse burst counter: synchronises a raw pulse line, counts rising edges per burst
// and reports each burst length via a valid/ready register. Optional: PULSE_GLITCH_FILTER_EN.
module pulse_burst_counter #(
  parameter int CNT_W   = 8,
  parameter int GAP_CYC = 4,
  parameter int GAP_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             len_ready,
  output logic             len_valid,
  output logic [CNT_W-1:0] len_data,
  output logic             overflow,
  output logic             busy,
  output logic             drop
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             sat, sat_nxt;
  logic [GAP_W-1:0] gap, gap_nxt;
  logic             load;

  logic s1, s2, s3;
  logic line;
  logic rise;

`ifdef PULSE_GLITCH_FILTER_EN
  logic s2_prev, s2f;

  // s2f only follows s2 once s2 has held the same value for two cycles
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      s2_prev <= 1'b0;
      s2f     <= 1'b0;
      s3      <= 1'b0;
    end else begin
      s1      <= sig_in;
      s2      <= s1;
      s2_prev <= s2;
      if (s2 == s2_prev)
        s2f <= s2;
      s3      <= s2f;
    end
  end

  assign line = s2f;
`else
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign line = s2;
`endif

  assign rise = line & ~s3;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      sat   <= 1'b0;
      gap   <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      sat   <= sat_nxt;
      gap   <= gap_nxt;
      busy  <= (state_nxt != IDLE);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sat_nxt   = sat;
    gap_nxt   = gap;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = COUNT;
          cnt_nxt   = CNT_W'(1);
          sat_nxt   = 1'b0;
          gap_nxt   = '0;
        end
      end
      COUNT: begin
        if (rise) begin
          gap_nxt = '0;
          if (cnt == '1)
            sat_nxt = 1'b1;
          else
            cnt_nxt = cnt + CNT_W'(1);
        end else if (line) begin
          gap_nxt = '0;
        end else if (gap == GAP_LAST) begin
          state_nxt = REPORT;
        end else begin
          gap_nxt = gap + GAP_W'(1);
        end
      end
      REPORT: begin
        load = 1'b1;
        // a rise landing on the report cycle opens the next burst immediately
        if (rise) begin
          state_nxt = COUNT;
          cnt_nxt   = CNT_W'(1);
          sat_nxt   = 1'b0;
          gap_nxt   = '0;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_valid <= 1'b0;
      len_data  <= '0;
      overflow  <= 1'b0;
      drop      <= 1'b0;
    end else begin
      drop <= 1'b0;
      if (load) begin
        if (!len_valid || len_ready) begin
          len_valid <= 1'b1;
          len_data  <= cnt;
          overflow  <= sat;
        end else begin
          drop <= 1'b1;
        end
      end else if (len_valid && len_ready) begin
        len_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pulse_burst_counter.sv
// Directed bench for pulse_burst_counter (GAP_CYC=4, CNT_W=8); inputs change 2ns after
// the rising edge, handshakes/drops are recorded on the falling edge.
module tb_pulse_burst_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sig_in;
  logic       len_ready;
  logic       len_valid;
  logic [7:0] len_data;
  logic       overflow;
  logic       busy;
  logic       drop;

  int errors = 0;
  int checks = 0;

  int         hs_cnt = 0;
  int         drop_cnt = 0;
  logic [7:0] hs_data = '0;
  logic       hs_ovf = 1'b0;

  always #5 clk = ~clk;

  pulse_burst_counter #(
    .CNT_W  (8),
    .GAP_CYC(4),
    .GAP_W  (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sig_in   (sig_in),
    .len_ready(len_ready),
    .len_valid(len_valid),
    .len_data (len_data),
    .overflow (overflow),
    .busy     (busy),
    .drop     (drop)
  );

  always @(negedge clk) begin
    if (rst_n === 1'b1 && len_valid === 1'b1 && len_ready === 1'b1) begin
      hs_cnt  <= hs_cnt + 1;
      hs_data <= len_data;
      hs_ovf  <= overflow;
    end
    if (drop === 1'b1)
      drop_cnt <= drop_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pulse(input int high, input int low);
    sig_in = 1'b1;
    tick(high);
    sig_in = 1'b0;
    tick(low);
  endtask

  task automatic burst(input int n);
    repeat (n) pulse(2, 2);
    tick(15);
  endtask

  int hs0;
  int drop0;

  initial begin
    rst_n     = 1'b0;
    sig_in    = 1'b0;
    len_ready = 1'b1;

    // 1: reset with sig_in toggling
    for (int i = 0; i < 3; i++) begin
      sig_in = ~sig_in;
      tick(1);
    end
    check("rst_valid", 32'(len_valid), 32'd0);
    check("rst_data", 32'(len_data), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_drop", 32'(drop), 32'd0);
    sig_in = 1'b0;
    rst_n  = 1'b1;
    tick(5);

    // 2: burst of 2, consumer always ready
    hs0 = hs_cnt;
    pulse(2, 2);
    check("b2_busy_mid", 32'(busy), 32'd1);
    pulse(2, 2);
    tick(15);
    check("b2_hs", 32'(hs_cnt - hs0), 32'd1);
    check("b2_data", 32'(hs_data), 32'd2);
    check("b2_ovf", 32'(hs_ovf), 32'd0);
    check("b2_valid_idle", 32'(len_valid), 32'd0);
    check("b2_busy_idle", 32'(busy), 32'd0);

    // 3: 300 pulses saturate the count
    hs0 = hs_cnt;
    burst(300);
    check("b300_hs", 32'(hs_cnt - hs0), 32'd1);
    check("b300_data", 32'(hs_data), 32'd255);
    check("b300_ovf", 32'(hs_ovf), 32'd1);

    // 4: consumer stalled, second burst dropped
    len_ready = 1'b0;
    hs0   = hs_cnt;
    drop0 = drop_cnt;
    burst(3);
    check("stall_valid1", 32'(len_valid), 32'd1);
    check("stall_data1", 32'(len_data), 32'd3);
    burst(5);
    check("stall_valid2", 32'(len_valid), 32'd1);
    check("stall_data2", 32'(len_data), 32'd3);
    check("stall_ovf", 32'(overflow), 32'd0);
    check("stall_drop", 32'(drop_cnt - drop0), 32'd1);
    check("stall_hs", 32'(hs_cnt - hs0), 32'd0);
    len_ready = 1'b1;
    tick(1);
    check("release_valid", 32'(len_valid), 32'd0);
    check("release_hs", 32'(hs_cnt - hs0), 32'd1);
    check("release_data", 32'(hs_data), 32'd3);
    tick(5);

    // 5: reset mid-burst discards the partial burst
    hs0 = hs_cnt;
    pulse(2, 2);
    pulse(2, 1);
    check("mid_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_valid", 32'(len_valid), 32'd0);
    tick(15);
    check("mid_hs", 32'(hs_cnt - hs0), 32'd0);
    burst(1);
    check("post_hs", 32'(hs_cnt - hs0), 32'd1);
    check("post_data", 32'(hs_data), 32'd1);

    // 6: one-cycle glitch, then a three-cycle pulse
    hs0 = hs_cnt;
    pulse(1, 0);
    tick(15);
`ifdef PULSE_GLITCH_FILTER_EN
    check("glitch_hs", 32'(hs_cnt - hs0), 32'd0);
`else
    check("glitch_hs", 32'(hs_cnt - hs0), 32'd1);
    check("glitch_data", 32'(hs_data), 32'd1);
`endif
    hs0 = hs_cnt;
    pulse(3, 0);
    tick(15);
    check("p3_hs", 32'(hs_cnt - hs0), 32'd1);
    check("p3_data", 32'(hs_data), 32'd1);
    check("p3_ovf", 32'(hs_ovf), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
